inv_mix_columns_seq: RTL and testbench

INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

---
 rtl/inv_mix_columns_seq_pkg.sv | 30 +++
 rtl/inv_mix_column_word.sv | 26 ++
 rtl/inv_mix_columns_seq.sv | 77 +++++++
 tb/tb_inv_mix_columns_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared GF(2^8)/AES definitions: reduction polynomial, FSM encodings and
// the xtime / constant-multiply helpers used by the column datapath.
package inv_mix_columns_seq_pkg;

    // Low byte of x^8+x^4+x^3+x+1
    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } imcState_t;

    // Multiply by x: shift left, reduce when the old MSB falls off
    function automatic logic [7:0] xtime(input logic [7:0] b, input logic [7:0] poly);
        return {b[6:0], 1'b0} ^ (b[7] ? poly : 8'h00);
    endfunction

    // Multiply by a 4-bit constant using chained xtime; stays 8 bits wide
    function automatic logic [7:0] gfMul(input logic [7:0] b, input logic [3:0] k,
                                         input logic [7:0] poly);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b, poly);
        x4 = xtime(x2, poly);
        x8 = xtime(x4, poly);
        return (k[0] ? b  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns for one 32-bit column; byte 0 is colIn[31:24].
module inv_mix_column_word #(
    parameter logic [7:0] GF_POLY = inv_mix_columns_seq_pkg::GF_POLY
) (
    input  logic [31:0] colIn,
    output logic [31:0] colOut
);
    import inv_mix_columns_seq_pkg::*;

    // a[i] / o[i] hold byte i of the column
    logic [3:0][7:0] a;
    logic [3:0][7:0] o;

    assign a = {colIn[7:0], colIn[15:8], colIn[23:16], colIn[31:24]};

    // Each output byte: 0E*a_i ^ 0B*a_(i+1) ^ 0D*a_(i+2) ^ 09*a_(i+3)
    for (genvar i = 0; i < 4; i++) begin : gLane
        assign o[i] = gfMul(a[i],           4'hE, GF_POLY) ^
                      gfMul(a[(i + 1) % 4], 4'hB, GF_POLY) ^
                      gfMul(a[(i + 2) % 4], 4'hD, GF_POLY) ^
                      gfMul(a[(i + 3) % 4], 4'h9, GF_POLY);
    end

    assign colOut = {o[0], o[1], o[2], o[3]};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: captures a 128-bit state, then transforms one
// column per cycle through a shared column datapath. Done pulses for one
// cycle when all four columns of StateOut are valid.
module inv_mix_columns_seq #(
    parameter logic [7:0] GF_POLY = inv_mix_columns_seq_pkg::GF_POLY
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [127:0] StateIn,
    output logic [127:0] StateOut,
    output logic         Busy,
    output logic         Done
);
    import inv_mix_columns_seq_pkg::*;

    imcState_t        state;
    logic [1:0]       colCnt;
    logic [3:0][31:0] inCols;   // inCols[3] is column 0 (MSBs)
    logic [3:0][31:0] resCols;
    logic [1:0]       slot;
    logic [31:0]      colIn;
    logic [31:0]      colOut;

    // Column c lives in packed slot 3-c so that column 0 is StateIn[127:96]
    assign slot  = 2'd3 - colCnt;
    assign colIn = inCols[slot];

    inv_mix_column_word #(.GF_POLY(GF_POLY)) uColumn (
        .colIn (colIn),
        .colOut(colOut)
    );

    assign StateOut = resCols;

    // Control FSM with registered Busy/Done; result written column-wise
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            colCnt  <= 2'd0;
            inCols  <= '0;
            resCols <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        inCols <= StateIn;
                        colCnt <= 2'd0;
                        Busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    resCols[slot] <= colOut;
                    colCnt        <= colCnt + 2'd1;
                    // Counter wraps to 0 here; the state change stops a fifth column
                    if (colCnt == 2'd3) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq: known vectors, latency, pulse
// width, back-to-back operation, reset abort and forward-model round trip.
module tb_inv_mix_columns_seq;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Start;
    logic [127:0] StateIn;
    logic [127:0] StateOut;
    logic         Busy;
    logic         Done;

    int nAsserts = 0;
    int nFail    = 0;

    localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] E2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V3 = 128'h01010101_9fdc589d_8e4da1bc_d5d5d7d6;
    localparam logic [127:0] E3 = 128'h01010101_f20a225c_db135345_d4d4d4d5;
    localparam logic [127:0] V4 = 128'h4d7ebdf8_c6c6c6c6_d5d5d7d6_8e4da1bc;
    localparam logic [127:0] E4 = 128'h2d26314c_c6c6c6c6_d4d4d4d5_db135345;

    always #5 Clk = ~Clk;

    inv_mix_columns_seq dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Start   (Start),
        .StateIn (StateIn),
        .StateOut(StateOut),
        .Busy    (Busy),
        .Done    (Done)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Forward MixColumns, used to undo the DUT result
    function automatic logic [31:0] mixCol(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [127:0] mixState(input logic [127:0] s);
        return {mixCol(s[127:96]), mixCol(s[95:64]), mixCol(s[63:32]), mixCol(s[31:0])};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transform; Start and garbage StateIn are driven during RUN to
    // show they are ignored. lat = negedges from the capture edge to Done.
    task automatic runBlock(input logic [127:0] din, output logic [127:0] dout, output int lat);
        @(negedge Clk);
        StateIn = din;
        Start   = 1'b1;
        lat     = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge Clk);
            if (n == 1) check("busy_in_run", Busy, 1'b1);
            if (Done) begin
                lat = n;
                break;
            end
            if (n < 4) begin
                Start   = 1'b1;
                StateIn = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                Start = 1'b0;
            end
        end
        Start = 1'b0;
        dout  = StateOut;
        check("busy_at_done", Busy, 1'b0);
        @(negedge Clk);
        check("done_one_cycle", Done, 1'b0);
        check("out_holds", StateOut, dout);
    endtask

    initial begin
        logic [127:0] res, r;
        logic [127:0] bv [3];
        logic [127:0] be [3];
        int lat, idx, last;
        logic doneSeen;

        // Reset, with Start asserted to show it has no effect
        Rst     = 1'b1;
        Start   = 1'b1;
        StateIn = V1;
        repeat (3) @(negedge Clk);
        check("rst_out", StateOut, 128'h0);
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        Rst   = 1'b0;
        Start = 1'b0;
        @(negedge Clk);
        check("idle_busy", Busy, 1'b0);

        runBlock(V1, res, lat);
        check("v1_out", res, E1);
        check("v1_lat", lat, 5);

        runBlock(V2, res, lat);
        check("v2_out", res, E2);
        check("v2_lat", lat, 5);

        runBlock(128'h0, res, lat);
        check("zero_out", res, 128'h0);
        check("zero_lat", lat, 5);

        // Back-to-back: Start held high, new StateIn at each Done cycle
        bv[0] = V3; be[0] = E3;
        bv[1] = V4; be[1] = E4;
        bv[2] = V1; be[2] = E1;
        @(negedge Clk);
        StateIn = bv[0];
        Start   = 1'b1;
        idx     = 0;
        last    = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge Clk);
            if (Done) begin
                check("b2b_out", StateOut, be[idx]);
                check("b2b_gap", n - last, 5);
                last = n;
                idx++;
                if (idx == 3) begin
                    Start = 1'b0;
                    break;
                end
                StateIn = bv[idx];
            end else begin
                StateIn = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        Start = 1'b0;
        check("b2b_count", idx, 3);
        @(negedge Clk);

        // Reset on the second RUN cycle aborts with no Done
        StateIn = V2;
        Start   = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Rst   = 1'b1;
        Start = 1'b1;
        @(negedge Clk);
        check("abort_out", StateOut, 128'h0);
        check("abort_busy", Busy, 1'b0);
        check("abort_done", Done, 1'b0);
        Rst      = 1'b0;
        Start    = 1'b0;
        doneSeen = 1'b0;
        repeat (8) begin
            @(negedge Clk);
            doneSeen = doneSeen | Done;
        end
        check("abort_no_done", doneSeen, 1'b0);
        check("abort_idle", Busy, 1'b0);

        runBlock(V2, res, lat);
        check("after_abort_out", res, E2);
        check("after_abort_lat", lat, 5);

        // Random round trip through the forward transform
        repeat (4) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            runBlock(r, res, lat);
            check("roundtrip", mixState(res), r);
            check("rand_lat", lat, 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
